// File: rtl/inst_fetch_mem_if.sv
// Fetch request/response, loader and status signals between the fetch stage,
// the program loader and the instruction memory.
interface inst_fetch_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic [1:0]  rsp_fault;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [7:0]  ld_byte;
  logic        ld_err;
  logic        init_done;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_valid, ld_addr, ld_byte,
    input  req_ready, rsp_valid, rsp_inst, rsp_fault, ld_ready, ld_err, init_done
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_valid, ld_addr, ld_byte,
    output req_ready, rsp_valid, rsp_inst, rsp_fault, ld_ready, ld_err, init_done
  );
endinterface

// File: rtl/inst_fetch_mem.sv
// Byte-loadable, little-endian instruction memory with a registered fetch response,
// NOP self-initialisation after reset and alignment/range fault reporting.
module inst_fetch_mem #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  inst_fetch_mem_if.slave   bus
);
  localparam int            IW       = $clog2(DEPTH);
  localparam logic [29:0]   DEPTH_W  = 30'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          init_done_q, init_done_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_inst_q, rsp_inst_d;
  logic [1:0]    rsp_fault_q, rsp_fault_d;
  logic          ld_err_q, ld_err_d;
  logic [31:0]   mem_q [DEPTH];

  logic          req_ready_s;
  logic          ld_ready_s;
  logic          req_acc_s;
  logic          ld_acc_s;
  logic          ld_in_range_s;
  logic          req_in_range_s;
  logic [IW-1:0] ld_idx_s;
  logic [IW-1:0] req_idx_s;

  // Range checks use the full 30-bit word index so far addresses never alias.
  assign ld_in_range_s  = (bus.ld_addr[31:2] < DEPTH_W);
  assign req_in_range_s = (bus.req_addr[31:2] < DEPTH_W);
  assign ld_idx_s       = bus.ld_addr[IW+1:2];
  assign req_idx_s      = bus.req_addr[IW+1:2];

  // Next-state, handshake and response logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_inst_d  = rsp_inst_q;
    rsp_fault_d = rsp_fault_q;
    ld_err_d    = 1'b0;
    ld_ready_s  = 1'b0;
    req_ready_s = 1'b0;
    ld_acc_s    = 1'b0;
    req_acc_s   = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_IDX) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      ST_RUN: begin
        // The loader always wins, so a fetch is never taken alongside a write.
        ld_ready_s  = 1'b1;
        req_ready_s = !bus.ld_valid && (!rsp_valid_q || bus.rsp_ready);
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    ld_acc_s  = bus.ld_valid && ld_ready_s;
    req_acc_s = bus.req_valid && req_ready_s;

    if (ld_acc_s && !ld_in_range_s) begin
      ld_err_d = 1'b1;
    end else begin
      ld_err_d = 1'b0;
    end

    if (req_acc_s) begin
      rsp_valid_d = 1'b1;
      if (bus.req_addr[1:0] != 2'b00) begin
        rsp_fault_d = 2'b01;
        rsp_inst_d  = NOP_WORD;
      end else if (!req_in_range_s) begin
        rsp_fault_d = 2'b10;
        rsp_inst_d  = NOP_WORD;
      end else begin
        rsp_fault_d = 2'b00;
        rsp_inst_d  = mem_q[req_idx_s];
      end
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= 32'h0000_0000;
      rsp_fault_q <= 2'b00;
      ld_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_inst_q  <= rsp_inst_d;
      rsp_fault_q <= rsp_fault_d;
      ld_err_q    <= ld_err_d;
    end
  end

  // Storage array: NOP sweep during INIT, single byte-lane writes in RUN.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= NOP_WORD;
    end else if (ld_acc_s && ld_in_range_s) begin
      mem_q[ld_idx_s][{bus.ld_addr[1:0], 3'b000} +: 8] <= bus.ld_byte;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.ld_ready  = ld_ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_inst  = rsp_inst_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.ld_err    = ld_err_q;
  assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_inst_fetch_mem.sv
// Directed bench for inst_fetch_mem (DEPTH=64): init sweep, byte loading,
// back-to-back fetches, faults, backpressure, loader priority and mid-run reset.
module tb_inst_fetch_mem;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   fails;

  inst_fetch_mem_if bus ();

  inst_fetch_mem #(.DEPTH(64), .NOP_WORD(32'h0000_0013)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_byte(input logic [31:0] addr, input logic [7:0] b);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_byte  = b;
    step();
    bus.ld_valid = 1'b0;
  endtask

  // Single fetch with rsp_ready=1; returns the response seen after the accept edge.
  task automatic fetch_one(input logic [31:0] addr, output logic v,
                           output logic [31:0] inst, output logic [1:0] fault);
    int n;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.rsp_ready = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      step();
      n++;
    end
    tests_run++;
    if (n >= 20) begin
      $display("FAIL fetch_wait: req_ready never rose for addr %h", addr);
      fails++;
    end
    step();
    bus.req_valid = 1'b0;
    v     = bus.rsp_valid;
    inst  = bus.rsp_inst;
    fault = bus.rsp_fault;
  endtask

  task automatic wait_init(output int edges);
    edges = 0;
    while (!bus.init_done && edges < 200) begin
      step();
      edges++;
    end
  endtask

  task automatic test_reset();
    int edges;
    logic v;
    logic [31:0] inst;
    logic [1:0] fault;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.req_ready, bus.ld_ready, bus.rsp_valid, bus.ld_err, bus.init_done} !== 5'b00000 ||
        bus.rsp_inst !== 32'h0 || bus.rsp_fault !== 2'b00) begin
      $display("FAIL reset_state: rdy=%b lrdy=%b v=%b err=%b done=%b inst=%h fault=%b, all zero required",
               bus.req_ready, bus.ld_ready, bus.rsp_valid, bus.ld_err, bus.init_done,
               bus.rsp_inst, bus.rsp_fault);
      fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(edges);
    tests_run++;
    if (edges !== 64) begin
      $display("FAIL init_edges: got %0d edges, required 64", edges);
      fails++;
    end
    tests_run++;
    if (bus.ld_ready !== 1'b1 || bus.req_ready !== 1'b1) begin
      $display("FAIL run_ready: ld_ready=%b req_ready=%b, required 1 1", bus.ld_ready, bus.req_ready);
      fails++;
    end
    fetch_one(32'h0, v, inst, fault);
    tests_run++;
    if (v !== 1'b1 || inst !== 32'h0000_0013 || fault !== 2'b00) begin
      $display("FAIL init_nop: v=%b inst=%h fault=%b, required 1 00000013 00", v, inst, fault);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes_a [8];
    bytes_a = '{8'h33, 8'h03, 8'h94, 8'h00, 8'hb3, 8'h03, 8'h39, 8'h41};
    for (int i = 0; i < 8; i++) load_byte(32'(i), bytes_a[i]);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    bus.rsp_ready = 1'b1;
    step();
    bus.req_addr = 32'h4;
    tests_run++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_inst !== 32'h0094_0333 || bus.rsp_fault !== 2'b00) begin
      $display("FAIL b2b_first: v=%b inst=%h fault=%b, required 1 00940333 00",
               bus.rsp_valid, bus.rsp_inst, bus.rsp_fault);
      fails++;
    end
    step();
    bus.req_valid = 1'b0;
    tests_run++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_inst !== 32'h4139_03b3 || bus.rsp_fault !== 2'b00) begin
      $display("FAIL b2b_second: v=%b inst=%h fault=%b, required 1 413903b3 00",
               bus.rsp_valid, bus.rsp_inst, bus.rsp_fault);
      fails++;
    end
    step();
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin
      $display("FAIL b2b_drain: rsp_valid=%b, required 0", bus.rsp_valid);
      fails++;
    end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [3];
    logic [1:0]  exp_f [3];
    logic v;
    logic [31:0] inst;
    logic [1:0] fault;
    addrs = '{32'h6, 32'h100, 32'h102};
    exp_f = '{2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 3; i++) begin
      fetch_one(addrs[i], v, inst, fault);
      tests_run++;
      if (v !== 1'b1 || inst !== 32'h0000_0013 || fault !== exp_f[i]) begin
        $display("FAIL fault_%h: v=%b inst=%h fault=%b, required 1 00000013 %b",
                 addrs[i], v, inst, fault, exp_f[i]);
        fails++;
      end
    end
  endtask

  task automatic test_hold();
    int bad;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    bus.req_addr  = 32'h4;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 ||
          bus.rsp_inst !== 32'h0094_0333 || bus.rsp_fault !== 2'b00) bad++;
      step();
    end
    tests_run++;
    if (bad !== 0) begin
      $display("FAIL hold_stable: %0d unstable cycles, required 0", bad);
      fails++;
    end
    bus.rsp_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin
      $display("FAIL hold_release_ready: req_ready=%b, required 1", bus.req_ready);
      fails++;
    end
    step();
    bus.req_valid = 1'b0;
    tests_run++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_inst !== 32'h4139_03b3) begin
      $display("FAIL hold_next: v=%b inst=%h, required 1 413903b3", bus.rsp_valid, bus.rsp_inst);
      fails++;
    end
    step();
  endtask

  task automatic test_loader_priority();
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h8;
    bus.rsp_ready = 1'b1;
    bus.ld_valid  = 1'b1;
    bus.ld_addr   = 32'h8;
    bus.ld_byte   = 8'hAA;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b0 || bus.ld_ready !== 1'b1) begin
      $display("FAIL ld_priority: req_ready=%b ld_ready=%b, required 0 1", bus.req_ready, bus.ld_ready);
      fails++;
    end
    step();
    bus.ld_valid = 1'b0;
    step();
    bus.req_valid = 1'b0;
    tests_run++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_inst !== 32'h0000_00AA || bus.rsp_fault !== 2'b00) begin
      $display("FAIL ld_visible: v=%b inst=%h fault=%b, required 1 000000aa 00",
               bus.rsp_valid, bus.rsp_inst, bus.rsp_fault);
      fails++;
    end
    step();
  endtask

  task automatic test_ld_err();
    logic v;
    logic [31:0] inst;
    logic [1:0] fault;
    load_byte(32'h200, 8'h55);
    tests_run++;
    if (bus.ld_err !== 1'b1) begin
      $display("FAIL ld_err_pulse: ld_err=%b, required 1", bus.ld_err);
      fails++;
    end
    step();
    tests_run++;
    if (bus.ld_err !== 1'b0) begin
      $display("FAIL ld_err_width: ld_err=%b, required 0", bus.ld_err);
      fails++;
    end
    fetch_one(32'h0, v, inst, fault);
    tests_run++;
    if (inst !== 32'h0094_0333 || fault !== 2'b00) begin
      $display("FAIL ld_err_noalias: inst=%h fault=%b, required 00940333 00", inst, fault);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    logic v;
    logic [31:0] inst;
    logic [1:0] fault;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    bus.rsp_ready = 1'b0;
    step();
    bus.req_valid = 1'b0;
    tests_run++;
    if (bus.rsp_valid !== 1'b1) begin
      $display("FAIL mid_pending: rsp_valid=%b, required 1", bus.rsp_valid);
      fails++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.init_done !== 1'b0) begin
      $display("FAIL mid_reset: rsp_valid=%b init_done=%b, required 0 0", bus.rsp_valid, bus.init_done);
      fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(edges);
    tests_run++;
    if (edges !== 64) begin
      $display("FAIL mid_init_edges: got %0d edges, required 64", edges);
      fails++;
    end
    fetch_one(32'h0, v, inst, fault);
    tests_run++;
    if (inst !== 32'h0000_0013 || fault !== 2'b00) begin
      $display("FAIL mid_reinit: inst=%h fault=%b, required 00000013 00", inst, fault);
      fails++;
    end
  endtask

  initial begin
    tests_run     = 0;
    fails         = 0;
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.rsp_ready = 1'b1;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = 32'h0;
    bus.ld_byte   = 8'h00;
    #3;
    test_reset();
    test_back_to_back();
    test_faults();
    test_hold();
    test_loader_priority();
    test_ld_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
